deflate_out_packetizer: RTL and testbench

Downstream stage of the Deflate core. It drains the core's output FIFO, which has a one-cycle read latency, through a 2-entry skid buffer and presents the words as a 32-bit AXI4-Stream master toward the output async FIFO. It splits the compressed stream into packets of a programmable length and marks the final word of the stream. It raises a sticky completion interrupt once that final word has been accepted downstream.

---
 rtl/deflate_pkg.sv | 14 +
 rtl/out_skid_buf.sv | 54 +++++
 rtl/deflate_out_packetizer.sv | 135 +++++++++++++
 tb/tb_deflate_out_packetizer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deflate_pkg.sv
// Shared types and width defaults for the Deflate output stage.
package deflate_pkg;

    localparam int unsigned DEFLATE_DATA_WIDTH = 32;
    localparam int unsigned DEFLATE_PKT_LEN_W  = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/out_skid_buf.sv
// Two-entry register FIFO between the core output FIFO and the AXI4-Stream port.
module out_skid_buf #(
    parameter int unsigned WIDTH = 33
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [1:0]       o_occ,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_ent0;
    logic [WIDTH-1:0] r_ent1;
    logic [1:0]       r_occ;

    // Entry 0 is always the head; a pop shifts entry 1 forward.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_occ  <= 2'd0;
            r_ent0 <= '0;
            r_ent1 <= '0;
        end else if (i_clr) begin
            r_occ <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_ent0 <= i_data;
                    else               r_ent1 <= i_data;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_ent0 <= r_ent1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_ent0 <= i_data;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_ent0;

endmodule

// File: rtl/deflate_out_packetizer.sv
// Drains the Deflate output FIFO into a packetised 32-bit AXI4-Stream master.
// Optional stream statistics counters are built when DEFLATE_OUT_STATS_EN is defined.
module deflate_out_packetizer
    import deflate_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFLATE_DATA_WIDTH,
    parameter int unsigned PKT_LEN_W  = DEFLATE_PKT_LEN_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic [PKT_LEN_W-1:0]  i_pkt_len,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rden,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    input  logic                  i_fifo_last,
    output logic [DATA_WIDTH-1:0] o_m_axis_tdata,
    output logic                  o_m_axis_tvalid,
    input  logic                  i_m_axis_tready,
    output logic                  o_m_axis_tlast,
    output logic                  o_m_axis_tuser,
    output logic [31:0]           o_stream_words,
    output logic [15:0]           o_pkt_count,
    output logic                  o_done,
    output logic                  o_irq
);

    state_e                r_state;
    logic                  r_inflight;
    logic [PKT_LEN_W-1:0]  r_pkt_len;
    logic [PKT_LEN_W-1:0]  r_beat_cnt;
    logic                  r_done;

    logic [1:0]            w_occ;
    logic [1:0]            w_pending;
    logic [DATA_WIDTH:0]   w_head;
    logic                  w_rden;
    logic                  w_push;
    logic                  w_tvalid;
    logic                  w_hs;
    logic                  w_word_last;
    logic                  w_tlast;

    // occ + inflight bounds the buffer: every issued read has a guaranteed slot.
    assign w_pending   = w_occ + {1'b0, r_inflight};
    assign w_rden      = (r_state == StRun) & ~i_fifo_empty & (w_pending < 2'd2);
    assign w_push      = r_inflight & (r_state == StRun);
    assign w_tvalid    = (w_occ != 2'd0);
    assign w_hs        = w_tvalid & i_m_axis_tready;
    assign w_word_last = w_head[DATA_WIDTH];
    assign w_tlast     = ((r_pkt_len != '0) && (r_beat_cnt == r_pkt_len - PKT_LEN_W'(1)))
                         || w_word_last;

    out_skid_buf #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (~i_enable),
        .i_push  (w_push),
        .i_data  ({i_fifo_last, i_fifo_data}),
        .i_pop   (w_hs),
        .o_occ   (w_occ),
        .o_head  (w_head)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_inflight <= 1'b0;
            r_pkt_len  <= '0;
            r_beat_cnt <= '0;
            r_done     <= 1'b0;
        end else if (!i_enable) begin
            r_state    <= StIdle;
            r_inflight <= 1'b0;
            r_beat_cnt <= '0;
            r_done     <= 1'b0;
        end else begin
            r_inflight <= w_rden;
            if (w_hs) r_beat_cnt <= w_tlast ? '0 : r_beat_cnt + PKT_LEN_W'(1);
            case (r_state)
                StIdle: begin
                    r_pkt_len  <= i_pkt_len;
                    r_beat_cnt <= '0;
                    r_state    <= StRun;
                end
                StRun: begin
                    if (r_inflight && i_fifo_last) r_state <= StDrain;
                end
                StDrain: begin
                    if (w_hs && w_word_last) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end
                end
                StDone: ;
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef DEFLATE_OUT_STATS_EN
    logic [31:0] r_stream_words;
    logic [15:0] r_pkt_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stream_words <= 32'd0;
            r_pkt_count    <= 16'd0;
        end else if (!i_enable) begin
            r_stream_words <= 32'd0;
            r_pkt_count    <= 16'd0;
        end else if (w_hs) begin
            r_stream_words <= r_stream_words + 32'd1;
            if (w_tlast) r_pkt_count <= r_pkt_count + 16'd1;
        end
    end

    assign o_stream_words = r_stream_words;
    assign o_pkt_count    = r_pkt_count;
`else
    assign o_stream_words = 32'd0;
    assign o_pkt_count    = 16'd0;
`endif

    assign o_fifo_rden     = w_rden;
    assign o_m_axis_tdata  = w_head[DATA_WIDTH-1:0];
    assign o_m_axis_tvalid = w_tvalid;
    assign o_m_axis_tlast  = w_tvalid & w_tlast;
    assign o_m_axis_tuser  = w_tvalid & w_word_last;
    assign o_done          = r_done;
    assign o_irq           = r_done;

endmodule

// File: tb/tb_deflate_out_packetizer.sv
// Randomised bench for deflate_out_packetizer against a queue-based stream model.
// Stats expectations follow DEFLATE_OUT_STATS_EN, as in the design.
module tb_deflate_out_packetizer;

`ifdef DEFLATE_OUT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] pkt_len = 16'd0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rden;
    logic [31:0] fifo_data = 32'd0;
    logic        fifo_last = 1'b0;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready = 1'b0;
    logic        tlast;
    logic        tuser;
    logic [31:0] stream_words;
    logic [15:0] pkt_count;
    logic        done;
    logic        irq;

    always #5 clk = ~clk;

    deflate_out_packetizer dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_enable        (enable),
        .i_pkt_len       (pkt_len),
        .i_fifo_empty    (fifo_empty),
        .o_fifo_rden     (fifo_rden),
        .i_fifo_data     (fifo_data),
        .i_fifo_last     (fifo_last),
        .o_m_axis_tdata  (tdata),
        .o_m_axis_tvalid (tvalid),
        .i_m_axis_tready (tready),
        .o_m_axis_tlast  (tlast),
        .o_m_axis_tuser  (tuser),
        .o_stream_words  (stream_words),
        .o_pkt_count     (pkt_count),
        .o_done          (done),
        .o_irq           (irq)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Model state: source FIFO contents and the beats expected downstream, in order.
    logic [32:0] src_q[$];
    logic [33:0] exp_q[$];
    int  cyc = 0;
    int  rmode = 0;
    int  gap_at = -1;
    int  gap_cnt = 0;
    int  gap_start = -100;
    int  resume_at = -100;
    bit  gap_used = 1'b0;
    int  issued = 0;
    int  accepted = 0;
    int  exp_pkts = 0;
    bit  en = 1'b0;
    bit  exp_done = 1'b0;
    bit  s_rden = 1'b0;
    bit  s_hs = 1'b0;
    bit  s_tuser = 1'b0;
    bit  s_en = 1'b0;
    bit  p_stall = 1'b0;
    logic [31:0] p_data = 32'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] st(input int v);
        return STATS ? 32'(v) : 32'd0;
    endfunction

    // One clock: apply inputs at the falling edge, then check what the next rising edge sees.
    task automatic cycle();
        logic [32:0] w;
        logic [33:0] e;
        @(negedge clk);
        cyc++;
        if (s_rden && src_q.size() > 0) begin
            w = src_q.pop_front();
            fifo_data = w[31:0];
            fifo_last = w[32];
        end else begin
            fifo_data = $urandom;
            fifo_last = 1'b0;
        end
        if (s_rden) issued++;
        if (s_hs) begin
            accepted++;
            if (s_tuser) exp_done = 1'b1;
        end
        if (!s_en) exp_done = 1'b0;
        if (gap_at >= 0 && !gap_used && issued == gap_at) begin
            gap_used = 1'b1;
            gap_cnt = 3;
            gap_start = cyc;
            resume_at = cyc + 3;
        end
        if (gap_at == -2) begin
            fifo_empty = (src_q.size() == 0) || ($urandom_range(3) == 0);
        end else if (gap_cnt > 0) begin
            fifo_empty = 1'b1;
            gap_cnt--;
        end else begin
            fifo_empty = (src_q.size() == 0);
        end
        case (rmode)
            0:       tready = 1'b1;
            1:       tready = cyc[0];
            2:       tready = 1'($urandom_range(1));
            default: tready = 1'b0;
        endcase
        enable = en;
        #1;
        check_eq("done", 32'(done), 32'(exp_done));
        check_eq("irq", 32'(irq), 32'(exp_done));
        if (p_stall && s_en) begin
            check_eq("stall_valid", 32'(tvalid), 32'd1);
            check_eq("stall_data", tdata, p_data);
        end
        if (tvalid) begin
            if (exp_q.size() == 0) begin
                check_eq("extra_beat", 32'(tvalid), 32'd0);
            end else begin
                e = exp_q[0];
                check_eq("tdata", tdata, e[31:0]);
                check_eq("tlast", 32'(tlast), 32'(e[32]));
                check_eq("tuser", 32'(tuser), 32'(e[33]));
                if (tready) void'(exp_q.pop_front());
            end
        end
        if (fifo_rden) check_eq("rden_room", 32'((issued - accepted) < 2), 32'd1);
        if (fifo_empty) check_eq("rden_empty", 32'(fifo_rden), 32'd0);
        if (cyc == gap_start + 2) check_eq("gap_drain", 32'(tvalid), 32'd0);
        if (cyc == resume_at + 1) check_eq("gap_lat1", 32'(tvalid), 32'd0);
        if (cyc == resume_at + 2) check_eq("gap_lat2", 32'(tvalid), 32'd1);
        s_rden  = fifo_rden;
        s_hs    = tvalid & tready;
        s_tuser = tuser;
        s_en    = enable;
        p_stall = tvalid & ~tready;
        p_data  = tdata;
    endtask

    task automatic start_stream(input int n, input int plen, input int rm, input int gp);
        logic [31:0] d;
        bit lst;
        bit tl;
        en = 1'b0;
        cycle();
        cycle();
        src_q.delete();
        exp_q.delete();
        issued = 0;
        accepted = 0;
        exp_pkts = 0;
        gap_used = 1'b0;
        gap_cnt = 0;
        gap_start = -100;
        resume_at = -100;
        gap_at = gp;
        rmode = rm;
        pkt_len = plen[15:0];
        for (int i = 0; i < n; i++) begin
            d = $urandom;
            lst = (i == n - 1);
            tl = lst || (plen != 0 && ((i + 1) % plen) == 0);
            if (tl) exp_pkts++;
            src_q.push_back({lst, d});
            exp_q.push_back({lst, tl, d});
        end
        en = 1'b1;
    endtask

    task automatic finish_stream(input int n);
        int budget = 0;
        while (!(exp_done && exp_q.size() == 0) && budget < 400) begin
            cycle();
            budget++;
        end
        check_eq("stream_done", 32'(exp_done), 32'd1);
        check_eq("stream_left", 32'(exp_q.size()), 32'd0);
        cycle();
        cycle();
        check_eq("tvalid_after", 32'(tvalid), 32'd0);
        check_eq("src_left", 32'(src_q.size()), 32'd0);
        check_eq("stream_words", stream_words, st(n));
        check_eq("pkt_count", 32'(pkt_count), st(exp_pkts));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        #3;
        check_eq("rst_tvalid", 32'(tvalid), 32'd0);
        check_eq("rst_tdata", tdata, 32'd0);
        check_eq("rst_tlast", 32'(tlast), 32'd0);
        check_eq("rst_tuser", 32'(tuser), 32'd0);
        check_eq("rst_rden", 32'(fifo_rden), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_words", stream_words, 32'd0);
        check_eq("rst_pkts", 32'(pkt_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        start_stream(10, 4, 0, -1);  finish_stream(10);
        start_stream(5, 0, 0, -1);   finish_stream(5);
        start_stream(8, 3, 1, -1);   finish_stream(8);
        start_stream(12, 0, 0, 4);   finish_stream(12);
        start_stream(4, 1, 2, -1);   finish_stream(4);
        start_stream(1, 5, 0, -1);   finish_stream(1);

        // Abort with a full buffer, then a fresh stream must start its counters from zero.
        start_stream(12, 3, 0, -1);
        repeat (6) cycle();
        rmode = 3;
        repeat (4) cycle();
        check_eq("abort_full", 32'(tvalid), 32'd1);
        check_eq("abort_words_pre", stream_words, st(accepted));
        en = 1'b0;
        cycle();
        src_q.delete();
        exp_q.delete();
        cycle();
        check_eq("abort_tvalid", 32'(tvalid), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_words", stream_words, st(0));
        check_eq("abort_pkts", 32'(pkt_count), st(0));
        start_stream(7, 2, 2, -1);   finish_stream(7);

        for (int k = 0; k < 4; k++) begin
            int n;
            n = $urandom_range(30, 1);
            start_stream(n, $urandom_range(6), 2, -2);
            finish_stream(n);
        end

        // Asynchronous reset in the middle of a packet.
        start_stream(10, 4, 0, -1);
        repeat (7) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_tvalid", 32'(tvalid), 32'd0);
        check_eq("arst_tdata", tdata, 32'd0);
        check_eq("arst_tlast", 32'(tlast), 32'd0);
        check_eq("arst_tuser", 32'(tuser), 32'd0);
        check_eq("arst_rden", 32'(fifo_rden), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        check_eq("arst_words", stream_words, 32'd0);
        check_eq("arst_pkts", 32'(pkt_count), 32'd0);
        en = 1'b0;
        src_q.delete();
        exp_q.delete();
        exp_done = 1'b0;
        s_rden = 1'b0;
        s_hs = 1'b0;
        s_tuser = 1'b0;
        p_stall = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        cycle();
        check_eq("post_rst_tvalid", 32'(tvalid), 32'd0);
        check_eq("post_rst_rden", 32'(fifo_rden), 32'd0);
        start_stream(3, 2, 0, -1);   finish_stream(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
